// File: rtl/drop_timer_pkg.sv
// Shared definitions for the fall-time datapath: Q8.8 widths and the drop_timer state encoding.
package drop_timer_pkg;

    localparam int Q_INT  = 8;
    localparam int Q_FRAC = 8;
    localparam int Q_W    = Q_INT + Q_FRAC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A 1-cycle prescaler still needs a 1-bit counter.
    function automatic int presc_width(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/drop_timer_tick_prescaler.sv
// Reloadable down-counter; tick marks the enabled cycle on which the count sits at zero.
module tick_prescaler
    import drop_timer_pkg::*;
#(
    parameter int TICKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic load,
    output logic tick
);

    localparam int            W      = presc_width(TICKS);
    localparam logic [W-1:0]  RELOAD = W'(TICKS - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en) begin
            cnt <= (cnt == '0) ? RELOAD : cnt - W'(1);
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/drop_timer.sv
// Counts a latched Q8.8 fall time down in prescaled clock ticks and issues a one-cycle drop.
//
// state | meaning
// IDLE  | waiting for a start request; start_ready high
// COUNT | remaining decrements once per prescaler tick; abort returns to IDLE
// DONE  | drop asserted for this single cycle, then back to IDLE
module drop_timer
    import drop_timer_pkg::*;
#(
    parameter int             TICKS_PER_LSB = 4,
    parameter logic [Q_W-1:0] MAX_T         = 16'h0F00
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [Q_W-1:0] t_in,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic           abort,
    output logic           busy,
    output logic [Q_W-1:0] remaining,
    output logic           drop,
    output logic           aborted,
    output logic           clamped
);

    state_t         state;
    logic [Q_W-1:0] t_sat;
    logic           accept;
    logic           presc_en;
    logic           tick;

    assign t_sat    = (t_in > MAX_T) ? MAX_T : t_in;
    assign accept   = start_valid && start_ready;
    assign presc_en = (state == COUNT) && !abort;

    tick_prescaler #(.TICKS(TICKS_PER_LSB)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (presc_en),
        .load  (accept),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            remaining   <= '0;
            drop        <= 1'b0;
            aborted     <= 1'b0;
            clamped     <= 1'b0;
        end else begin
            drop    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        clamped     <= (t_in > MAX_T);
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        remaining   <= t_sat;
                        if (t_sat == '0) begin
                            state <= DONE;
                            drop  <= 1'b1;
                        end else begin
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    // Abort wins over a coincident final decrement, so drop never fires.
                    if (abort) begin
                        state       <= IDLE;
                        remaining   <= '0;
                        aborted     <= 1'b1;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end else if (tick && remaining != '0) begin
                        remaining <= remaining - Q_W'(1);
                        if (remaining == Q_W'(1)) begin
                            state <= DONE;
                            drop  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    remaining   <= '0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    remaining   <= '0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drop_timer.sv
// Directed checks of drop_timer with default parameters (4 clocks per LSB, MAX_T = 15.0).
module tb_drop_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] t_in = '0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic        abort = 1'b0;
    logic        busy;
    logic [15:0] remaining;
    logic        drop;
    logic        aborted;
    logic        clamped;

    int total = 0;
    int bad   = 0;

    drop_timer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .t_in        (t_in),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .abort       (abort),
        .busy        (busy),
        .remaining   (remaining),
        .drop        (drop),
        .aborted     (aborted),
        .clamped     (clamped)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge right after the accepting edge E0 (k=0).
    task automatic do_accept(input logic [15:0] t, input logic hold);
        int w = 0;
        while (start_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (start_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready: start_ready=%b required 1", start_ready);
        end
        t_in = t;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({start_ready, busy, remaining, drop, aborted, clamped} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: rdy=%b busy=%b rem=%h drop=%b abt=%b clp=%b required 1 0 0000 0 0 0",
                     start_ready, busy, remaining, drop, aborted, clamped);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] exp_rem;
        do_accept(16'h0003, 1'b0);
        for (int k = 0; k <= 14; k++) begin
            exp_rem = (k < 4) ? 16'd3 : (k < 8) ? 16'd2 : (k < 12) ? 16'd1 : 16'd0;
            total++;
            if ({remaining, drop, busy, start_ready} !== {exp_rem, k == 12, k <= 12, k >= 13}) begin
                bad++;
                $display("FAIL basic k=%0d: rem=%h drop=%b busy=%b rdy=%b required %h %b %b %b",
                         k, remaining, drop, busy, start_ready, exp_rem, k == 12, k <= 12, k >= 13);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero();
        do_accept(16'h0000, 1'b0);
        total++;
        if ({drop, busy, remaining, clamped} !== {1'b1, 1'b1, 16'h0, 1'b0}) begin
            bad++;
            $display("FAIL zero_drop: drop=%b busy=%b rem=%h clp=%b required 1 1 0000 0",
                     drop, busy, remaining, clamped);
        end
        @(negedge clk);
        total++;
        if ({drop, start_ready} !== 2'b01) begin
            bad++;
            $display("FAIL zero_after: drop=%b rdy=%b required 0 1", drop, start_ready);
        end
    endtask

    task automatic test_clamp();
        int k = 0;
        do_accept(16'hFFFF, 1'b0);
        total++;
        if ({clamped, remaining} !== {1'b1, 16'h0F00}) begin
            bad++;
            $display("FAIL clamp_latch: clp=%b rem=%h required 1 0f00", clamped, remaining);
        end
        while (drop !== 1'b1 && k < 16000) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (drop !== 1'b1 || k != 15360) begin
            bad++;
            $display("FAIL clamp_latency: drop=%b at k=%0d required 1 at 15360", drop, k);
        end
        @(negedge clk);
        do_accept(16'h0001, 1'b0);
        total++;
        if ({clamped, remaining} !== {1'b0, 16'h0001}) begin
            bad++;
            $display("FAIL clamp_clear: clp=%b rem=%h required 0 0001", clamped, remaining);
        end
        repeat (4) @(negedge clk);
        total++;
        if (drop !== 1'b1) begin
            bad++;
            $display("FAIL clamp_follow_drop: drop=%b required 1", drop);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int drops = 0;
        do_accept(16'h0010, 1'b0);
        for (int k = 0; k <= 80; k++) begin
            if (drop === 1'b1) drops++;
            if (k == 19) begin
                total++;
                if (remaining !== 16'h000C) begin
                    bad++;
                    $display("FAIL abort_pre: rem=%h required 000c", remaining);
                end
                abort = 1'b1;
            end
            if (k == 20) begin
                total++;
                if ({aborted, remaining, busy, start_ready} !== {1'b1, 16'h0, 1'b0, 1'b1}) begin
                    bad++;
                    $display("FAIL abort_pulse: abt=%b rem=%h busy=%b rdy=%b required 1 0000 0 1",
                             aborted, remaining, busy, start_ready);
                end
            end
            if (k == 21) begin
                abort = 1'b0;
                total++;
                if ({aborted, start_ready} !== 2'b01) begin
                    bad++;
                    $display("FAIL abort_second_ignored: abt=%b rdy=%b required 0 1", aborted, start_ready);
                end
            end
            @(negedge clk);
        end
        total++;
        if (drops != 0) begin
            bad++;
            $display("FAIL abort_no_drop: drop cycles=%0d required 0", drops);
        end
    endtask

    task automatic test_abort_final();
        int drops = 0;
        do_accept(16'h0001, 1'b0);
        for (int k = 0; k <= 15; k++) begin
            if (drop === 1'b1) drops++;
            if (k == 3) abort = 1'b1;
            if (k == 4) begin
                abort = 1'b0;
                total++;
                if ({aborted, drop, remaining} !== {1'b1, 1'b0, 16'h0}) begin
                    bad++;
                    $display("FAIL abort_final: abt=%b drop=%b rem=%h required 1 0 0000",
                             aborted, drop, remaining);
                end
            end
            @(negedge clk);
        end
        total++;
        if (drops != 0) begin
            bad++;
            $display("FAIL abort_final_no_drop: drop cycles=%0d required 0", drops);
        end
    endtask

    task automatic test_async_reset();
        int drops = 0;
        do_accept(16'h0005, 1'b1);
        t_in = 16'h0009;
        repeat (3) @(negedge clk);
        total++;
        if ({remaining, start_ready, busy} !== {16'h0005, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL busy_ignores_valid: rem=%h rdy=%b busy=%b required 0005 0 1",
                     remaining, start_ready, busy);
        end
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        start_valid = 1'b0;
        #1;
        total++;
        if ({start_ready, busy, remaining, drop, aborted, clamped} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: rdy=%b busy=%b rem=%h drop=%b abt=%b clp=%b required 1 0 0000 0 0 0",
                     start_ready, busy, remaining, drop, aborted, clamped);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (drop === 1'b1) drops++;
            @(negedge clk);
        end
        total++;
        if (drops != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_drop: drop cycles=%0d busy=%b required 0 0", drops, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_clamp();
        test_abort();
        test_abort_final();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/drop_timer.md
Name: drop_timer

Overview:
- Downstream consumer of the Q8.8 fall-time value produced by the square-root stage.
- Latches a requested fall time, counts it down in real clock ticks through a prescaler, and emits a one-cycle drop command when the count expires.
- Provides a valid/ready start handshake, abort, a remaining-time readout for the display stage, and a clamp for out-of-range requests.

Parameters:
- TICKS_PER_LSB, 4: clock cycles per 1/256 time unit; legal range 1..65535.
- MAX_T, 16'h0F00: largest accepted fall time (Q8.8, 15.0); larger requests are clamped to this value.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- t_in  in  16  requested fall time, unsigned Q8.8 (8 integer bits, 8 fraction bits).
- start_valid  in  1  t_in is valid; a transfer occurs on an edge where start_valid && start_ready.
- start_ready  out  1  high only in IDLE.
- abort  in  1  cancels an active countdown.
- busy  out  1  high in COUNT and DONE.
- remaining  out  16  remaining time, Q8.8.
- drop  out  1  one-cycle drop command.
- aborted  out  1  one-cycle pulse after an abort.
- clamped  out  1  sticky flag: the last accepted request exceeded MAX_T.

Behaviour:
- All outputs are registered.
- Reset values: start_ready=1 and every other output 0; state=IDLE; prescaler=0.
- States: IDLE, COUNT, DONE.
- IDLE:
  - On accept, latch T = min(t_in, MAX_T).
  - Set clamped = (t_in > MAX_T); clamped keeps that value until the next accept.
  - If T==0, go to DONE; otherwise go to COUNT with remaining=T and prescaler=TICKS_PER_LSB-1.
  - abort is ignored in IDLE.
- COUNT, evaluated every cycle:
  - If abort: go to IDLE, remaining=0, aborted=1 for one cycle. abort takes priority over a coincident final decrement; drop is never issued.
  - Else if prescaler==0: remaining -= 1 and prescaler reloads to TICKS_PER_LSB-1. If remaining was 1, go to DONE.
  - Else: prescaler -= 1.
- DONE: drop=1 for exactly this one cycle, remaining=0, then go to IDLE unconditionally.
- Latency: if accept occurs on edge E0, drop is high during the cycle beginning at edge E0 + T*TICKS_PER_LSB. For T=0 that is the cycle right after E0.
- start_ready is low in COUNT and DONE, so start_valid is ignored while busy. A new accept is possible on the edge that ends DONE's cycle + 1, i.e. one cycle after drop.
- Widths:
  - remaining decrement never wraps; 0 is terminal.
  - prescaler width is $clog2(TICKS_PER_LSB) with a minimum of 1. TICKS_PER_LSB=1 means remaining decrements every cycle.
- Reset asserted mid-operation immediately returns the block to reset values; no drop is issued.
- Back-to-back abort pulses are ignored after the first, because the block is already in IDLE.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, COUNT, DONE);
  - the Q8.8 width constants: Q_INT=8, Q_FRAC=8, Q_W=16. The square-root stage also uses these.
- One sub-module is natural: tick_prescaler, a reloadable down-counter with a tick output, enable and load inputs.
- The FSM and the remaining-time register stay in drop_timer.

Test Plan:
- Basic countdown (defaults): t_in=16'h0003 accepted at E0 -> remaining steps 3,2,1,0 at E0+4, +8, +12; drop high only in the cycle after E0+12; busy falls with it; start_ready returns high.
- Zero time: t_in=0 -> drop in the cycle immediately after accept; clamped=0.
- Clamp: t_in=16'hFFFF -> clamped=1 and remaining=16'h0F00 after accept; drop at E0+0x0F00*4. A following request t_in=1 clears clamped.
- Abort: t_in=16'h0010, assert abort at E0+20 -> aborted one cycle, remaining=0, no drop ever; start_ready=1 next cycle.
- Abort coincident with the final decrement (t_in=1, abort at E0+4) -> aborted=1, drop=0.
- Async reset at E0+6 of a t_in=16'h0005 countdown -> outputs clear without a clock edge; no drop; start_valid held high while busy is never accepted, checked before the reset.
